channel_picker: RTL and testbench
=================================

Name: channel_picker

Overview:
- Parametrised successor stage for the channelizer output stream.
- Consumes the interleaved channel-sample stream (data, nd, m, first-channel marker) and tracks channel index with a frame-sync state machine.
- Forwards only channels enabled in a runtime-programmable mask, tagged with channel index, through a buffered valid/ready output.
- Detects sync loss and overflow.

Parameters:
- N, 16, number of interleaved channels per frame.
- LOGN, 4, channel index width; N <= 2**LOGN.
- WDTH, 32, sample data width.
- MWDTH, 1, metadata width, passed through unchanged.
- FDEPTH, 16, output FIFO depth in entries.
- LOGFD, 4, log2(FDEPTH); FDEPTH must equal 2**LOGFD.

Ports:
- clk, in, 1, clock; single clock domain.
- rst, in, 1, reset; synchronous, active-high.
- in_data, in, WDTH, channel sample.
- in_nd, in, 1, in_data/in_m/in_first valid this cycle; no backpressure upstream.
- in_m, in, MWDTH, metadata.
- in_first, in, 1, sample is channel 0 of a frame; qualified by in_nd.
- mask_wr, in, 1, load mask_data into pending mask.
- mask_data, in, N, bit k=1 enables channel k.
- out_data, out, WDTH, selected sample.
- out_m, out, MWDTH, metadata of selected sample.
- out_ch, out, LOGN, channel index of selected sample.
- out_first, out, 1, sample is the first selected channel of its frame.
- out_nd, out, 1, output valid (FIFO not empty).
- out_ready, in, 1, downstream accepts; transfer when out_nd && out_ready.
- error, out, 1, sticky fault flag; cleared only by rst.

Behaviour:
- Reset values:
  - out_nd=0, out_data/out_m/out_ch/out_first=0, error=0.
  - State SEEK, channel counter cnt=0, FIFO empty.
  - Active mask and pending mask set to all ones.
- States:
  - SEEK: samples are discarded. On in_nd && in_first, go to LOCKED, treat that sample as channel 0, and process it.
  - LOCKED: each in_nd sample has channel index cnt. After processing, cnt <= (cnt==N-1) ? 0 : cnt+1.
- Sync checks (LOCKED, in_nd only):
  - in_first with cnt!=0: set error; force cnt to 0; process the sample as channel 0; stay LOCKED.
  - cnt==0 without in_first: set error; discard the sample; go to SEEK.
- Mask update:
  - mask_wr loads pending mask.
  - Active mask <= pending mask when a channel-0 sample is processed.
  - If mask_wr coincides with that sample, mask_data is forwarded into the active mask for the frame.
  - Mask never changes mid-frame.
- Selection:
  - A processed sample with active_mask[ch]=1 is pushed as {data, m, ch, first}.
  - first=1 only for the lowest-index enabled channel of the frame.
  - Active mask all zero: no output, no error.
- FIFO:
  - Show-ahead; the outputs present the head entry.
  - A push at edge t makes the entry visible with out_nd=1 from cycle t+1. There is no same-cycle bypass: push while empty gives out_nd high only in the next cycle.
  - Pop on out_nd && out_ready; the next entry appears in the following cycle.
  - Push while full with no pop: sample dropped and error set.
  - Push and pop in the same cycle while full: both succeed; occupancy unchanged; no error.
  - out_data/out_m/out_ch/out_first hold stable while out_nd=1 and out_ready=0.
- Reset mid-frame:
  - FIFO is flushed, error is cleared, and state returns to SEEK on the next edge.
  - Samples in the reset cycle are ignored.
- Throughput: one input sample per clock sustained; latency from input to out_nd is 1 cycle when the FIFO is empty.

Decomposition:
- Shared defines header holds:
  - state encodings SEEK/LOCKED;
  - FIFO entry width macro WDTH+MWDTH+LOGN+1;
  - testbench defaults for N/LOGN/WDTH/MWDTH.
- One sub-module, sync_fifo: parameters width and depth; ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full. It is reusable elsewhere in the codebase.
- channel_picker holds the sync FSM, channel counter, mask registers and selection logic.

Test Plan:
1. Steady-state selection. N=8, mask=8'b00100101, out_ready=1, continuous frames with in_data = frame*8+ch. Outputs per frame are ch 0, 2, 5, with out_first=1 on ch 0 only; data values match; error=0.
2. SEEK entry. Stream starts mid-frame at ch 5 (in_first low). Samples for ch 5–7 are discarded; output starts with ch 0 of the next frame.
3. Sync fault. in_first asserted at cnt=3. error=1 next cycle and stays high; that sample is output as ch 0 (mask all ones); subsequent samples are labelled 1, 2, ...
4. Mask timing. mask_wr=8'h80 issued at ch 4 of frame k. Frame k still uses the old mask; from frame k+1 only ch 7 is output, with out_first=1. A second case issues mask_wr coincident with ch 0: the new mask applies to the same frame.
5. Overflow. FDEPTH=16, out_ready=0, mask all ones, 20 samples. Exactly 16 are buffered and error=1 at the 17th push. Then out_ready=1 drains 16 entries in order, with out_nd falling after the last.
6. Full push+pop and mid-run rst. FIFO full, push and pop in the same cycle: no error, order preserved. Then rst=1 for 1 cycle: next cycle out_nd=0 and error=0; resync on the next in_first.

Source files
------------

// File: rtl/channel_picker_pkg.sv
// Shared types and constants for the channel picker: frame-sync states,
// FIFO entry width and the default sizing used by the bench.
package channel_picker_pkg;

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int TB_N     = 8;
  localparam int TB_LOGN  = 3;
  localparam int TB_WDTH  = 32;
  localparam int TB_MWDTH = 1;

  // One buffered entry is {data, m, ch, first}.
  function automatic int entry_w(input int wdth, input int mwdth, input int logn);
    return wdth + mwdth + logn + 1;
  endfunction

endpackage

// File: rtl/channel_picker_if.sv
// Bundles the channelizer input stream, mask programming port and the
// buffered valid/ready output of the channel picker.
interface channel_picker_if #(
  parameter int N     = 16,
  parameter int LOGN  = 4,
  parameter int WDTH  = 32,
  parameter int MWDTH = 1
);

  logic [WDTH-1:0]  in_data;
  logic             in_nd;
  logic [MWDTH-1:0] in_m;
  logic             in_first;
  logic             mask_wr;
  logic [N-1:0]     mask_data;
  logic [WDTH-1:0]  out_data;
  logic [MWDTH-1:0] out_m;
  logic [LOGN-1:0]  out_ch;
  logic             out_first;
  logic             out_nd;
  logic             out_ready;
  logic             error;

  modport master (
    output in_data, in_nd, in_m, in_first, mask_wr, mask_data, out_ready,
    input  out_data, out_m, out_ch, out_first, out_nd, error
  );

  modport slave (
    input  in_data, in_nd, in_m, in_first, mask_wr, mask_data, out_ready,
    output out_data, out_m, out_ch, out_first, out_nd, error
  );

endinterface

// File: rtl/channel_picker_sync_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted only when a
// read happens in the same cycle. Read data is forced to zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/channel_picker.sv
// Frame-synchronised channel selector: tracks the channel index of the
// interleaved stream and buffers the masked channels for a valid/ready sink.
module channel_picker
  import channel_picker_pkg::*;
#(
  parameter int N      = 16,
  parameter int LOGN   = 4,
  parameter int WDTH   = 32,
  parameter int MWDTH  = 1,
  parameter int FDEPTH = 16,
  parameter int LOGFD  = 4
) (
  input logic             clk,
  input logic             rst,
  channel_picker_if.slave bus
);

  localparam int EW = entry_w(WDTH, MWDTH, LOGN);
  // LOGFD is authoritative when the two sizing parameters disagree.
  localparam int DEPTH = (FDEPTH == (1 << LOGFD)) ? FDEPTH : (1 << LOGFD);
  localparam logic [LOGN-1:0] LAST_CH = LOGN'(N - 1);

  state_e          state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [N-1:0]    act_mask_q, act_mask_d;
  logic [N-1:0]    pend_mask_q, pend_mask_d;
  logic            err_q, err_d;

  logic            proc, sync_err, push, pop, first_sel;
  logic [LOGN-1:0] ch;
  logic [N-1:0]    eff_mask;
  logic [EW-1:0]   push_word, head_word;
  logic            fifo_full, fifo_empty;

  function automatic logic lowest_set(input logic [N-1:0] m, input logic [LOGN-1:0] c);
    logic r;
    r = m[c];
    for (int k = 0; k < N; k++) begin
      if (k < int'(c) && m[k]) r = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_mask_d  = act_mask_q;
    pend_mask_d = bus.mask_wr ? bus.mask_data : pend_mask_q;
    proc        = 1'b0;
    sync_err    = 1'b0;
    ch          = cnt_q;
    if (bus.in_nd) begin
      if (state_q == SEEK) begin
        if (bus.in_first) begin
          state_d = LOCKED;
          proc    = 1'b1;
          ch      = '0;
        end
      end else if (bus.in_first) begin
        sync_err = (cnt_q != '0);
        proc     = 1'b1;
        ch       = '0;
      end else if (cnt_q == '0) begin
        sync_err = 1'b1;
        state_d  = SEEK;
      end else begin
        proc = 1'b1;
      end
    end
    // The mask only switches on a frame boundary; a coincident write takes effect at once.
    eff_mask = act_mask_q;
    if (proc && ch == '0) begin
      eff_mask   = bus.mask_wr ? bus.mask_data : pend_mask_q;
      act_mask_d = eff_mask;
    end
    if (proc) cnt_d = (ch == LAST_CH) ? '0 : ch + LOGN'(1);
    push      = proc && eff_mask[ch];
    first_sel = lowest_set(eff_mask, ch);
    push_word = {bus.in_data, bus.in_m, ch, first_sel};
    pop       = !fifo_empty && bus.out_ready;
    err_d     = err_q | sync_err | (push && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEEK;
      cnt_q       <= '0;
      act_mask_q  <= '1;
      pend_mask_q <= '1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_mask_q  <= act_mask_d;
      pend_mask_q <= pend_mask_d;
      err_q       <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(push_word),
    .rd_en  (pop),
    .rd_data(head_word),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign {bus.out_data, bus.out_m, bus.out_ch, bus.out_first} = head_word;
  assign bus.out_nd = !fifo_empty;
  assign bus.error  = err_q;

endmodule

// File: tb/tb_channel_picker.sv
// Randomised bench for channel_picker with directed phases for selection,
// sync recovery, mask timing, overflow and reset, against a queue-based model.
module tb_channel_picker;
  import channel_picker_pkg::*;

  localparam int N      = TB_N;
  localparam int LOGN   = TB_LOGN;
  localparam int WDTH   = TB_WDTH;
  localparam int MWDTH  = TB_MWDTH;
  localparam int FDEPTH = 16;
  localparam int LOGFD  = 4;
  localparam int EW     = entry_w(WDTH, MWDTH, LOGN);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  channel_picker_if #(.N(N), .LOGN(LOGN), .WDTH(WDTH), .MWDTH(MWDTH)) bus ();

  channel_picker #(
    .N(N), .LOGN(LOGN), .WDTH(WDTH), .MWDTH(MWDTH), .FDEPTH(FDEPTH), .LOGFD(LOGFD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: lock flag, expected channel number, masks and a queue of entries.
  bit            m_locked;
  int            m_cnt;
  logic [N-1:0]  m_act, m_pend;
  bit            m_err;
  logic [EW-1:0] m_q[$];

  task automatic model_step();
    bit           pop, proc;
    int           ch;
    logic [N-1:0] below;
    logic [EW-1:0] e;
    if (rst) begin
      m_locked = 0; m_cnt = 0; m_act = '1; m_pend = '1; m_err = 0;
      m_q.delete();
      return;
    end
    pop  = (m_q.size() > 0) && bus.out_ready;
    proc = 0;
    ch   = m_cnt;
    if (bus.in_nd) begin
      if (!m_locked) begin
        if (bus.in_first) begin m_locked = 1; ch = 0; proc = 1; end
      end else if (bus.in_first) begin
        if (m_cnt != 0) m_err = 1;
        ch = 0; proc = 1;
      end else if (m_cnt == 0) begin
        m_err = 1; m_locked = 0;
      end else begin
        proc = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (proc) begin
      if (ch == 0) m_act = bus.mask_wr ? bus.mask_data : m_pend;
      if (m_act[ch]) begin
        below = m_act & ((N'(1) << ch) - N'(1));
        e = {bus.in_data, bus.in_m, LOGN'(ch), (below == '0)};
        if (m_q.size() >= FDEPTH) m_err = 1;
        else m_q.push_back(e);
      end
      m_cnt = (ch + 1) % N;
    end
    if (bus.mask_wr) m_pend = bus.mask_data;
  endtask

  task automatic check_out();
    logic [EW-1:0] exp;
    exp = (m_q.size() > 0) ? m_q[0] : '0;
    chk("out_nd", 64'(bus.out_nd), 64'(m_q.size() > 0));
    chk("head", 64'({bus.out_data, bus.out_m, bus.out_ch, bus.out_first}), 64'(exp));
    chk("error", 64'(bus.error), 64'(m_err));
  endtask

  task automatic cyc(input logic nd, input logic fst, input logic [WDTH-1:0] d,
                     input logic mw, input logic [N-1:0] md, input logic rdy, input logic r);
    @(negedge clk);
    rst           = r;
    bus.in_nd     = nd;
    bus.in_first  = fst;
    bus.in_data   = d;
    bus.in_m      = MWDTH'($urandom);
    bus.mask_wr   = mw;
    bus.mask_data = md;
    bus.out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_out();
  endtask

  // Upstream source position; in_first follows it unless a fault is injected.
  int src   = 0;
  int frame = 0;

  task automatic send(input int n, input int nd_pct, input int rdy_pct,
                      input int fault_pct, input int mw_pct);
    for (int i = 0; i < n; i++) begin
      logic nd, fst, mw, rdy;
      nd  = ($urandom_range(99) < nd_pct);
      fst = (src == 0);
      if ($urandom_range(99) < fault_pct) fst = ~fst;
      mw  = ($urandom_range(99) < mw_pct);
      rdy = ($urandom_range(99) < rdy_pct);
      cyc(nd, fst, WDTH'(frame * N + src), mw, N'($urandom), rdy, 1'b0);
      if (nd) begin
        src = (src + 1) % N;
        if (src == 0) frame++;
      end
    end
  endtask

  task automatic sample_now(input logic fst, input logic mw, input logic [N-1:0] md,
                            input logic rdy);
    cyc(1'b1, fst, WDTH'(frame * N + src), mw, md, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, WDTH'(32'hDEAD), 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_nd = 1'b0; bus.in_first = 1'b0; bus.in_data = '0; bus.in_m = '0;
    bus.mask_wr = 1'b0; bus.mask_data = '0; bus.out_ready = 1'b1;

    do_reset();
    do_reset();

    // Steady selection with the stream entering mid-frame at channel 5.
    cyc(1'b0, 1'b0, '0, 1'b1, N'(8'b0010_0101), 1'b1, 1'b0);
    src = 5; frame = 0;
    send(40, 100, 100, 0, 0);

    // Early in_first at channel 3, with all channels enabled.
    cyc(1'b0, 1'b0, '0, 1'b1, '1, 1'b1, 1'b0);
    send(N, 100, 100, 0, 0);
    while (src != 3) send(1, 100, 100, 0, 0);
    sample_now(1'b1, 1'b0, '0, 1'b1);
    src = 1;
    send(2 * N, 100, 100, 0, 0);

    // Missing in_first at channel 0 drops back to SEEK.
    while (src != 0) send(1, 100, 100, 0, 0);
    sample_now(1'b0, 1'b0, '0, 1'b1);
    src = 1;
    send(2 * N, 100, 100, 0, 0);

    // Mask written mid-frame, then coincident with channel 0.
    do_reset();
    send(2 * N, 100, 100, 0, 0);
    while (src != 4) send(1, 100, 100, 0, 0);
    sample_now(1'b0, 1'b1, N'(8'h80), 1'b1);
    src++;
    send(2 * N, 100, 100, 0, 0);
    while (src != 0) send(1, 100, 100, 0, 0);
    sample_now(1'b1, 1'b1, N'(8'h24), 1'b1);
    src = 1;
    send(2 * N, 100, 100, 0, 0);

    // Overflow with the sink stalled, then a full drain.
    do_reset();
    while (src != 0) send(1, 100, 0, 0, 0);
    send(20, 100, 0, 0, 0);
    send(20, 0, 100, 0, 0);

    // Push and pop together while full, then reset mid-frame and resync.
    do_reset();
    while (src != 0) send(1, 100, 0, 0, 0);
    send(FDEPTH, 100, 0, 0, 0);
    send(4, 100, 100, 0, 0);
    send(3, 100, 0, 0, 0);
    do_reset();
    src = (src + 1) % N;
    send(3 * N, 100, 50, 0, 0);

    // Random traffic with occasional sync faults, mask writes and resets.
    for (int r = 0; r < 30; r++) begin
      send(100, 80, 60, 2, 5);
      if ($urandom_range(3) == 0) do_reset();
    end
    send(40, 0, 100, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
